// File: rtl/axi4_lite_master_arbiter_pkg.sv
// Shared types for the AXI4-Lite master arbiter: response codes, FSM states and the
// constant protection value driven on AWPROT/ARPROT.
package axi4_lite_master_arbiter_pkg;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespExOkay = 2'b01,
    RespSlvErr = 2'b10,
    RespDecErr = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    StIdle,
    StWrAwW,
    StWrB,
    StRdAr,
    StRdR,
    StRsp
  } state_t;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi4_lite_master_arbiter_if.sv
// AXI4-Lite bus bundle between the arbiter (master) and a register slave.
interface axi4_lite_master_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid,
           rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid,
           rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_master_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above i_ptr, wrapping at N.
module axi4_lite_master_arbiter_rr_arbiter #(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_grant_idx
);

  int unsigned w_idx;
  logic        w_found;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_idx       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = (32'(i_ptr) + k) % N;
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = IDX_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/axi4_lite_master_arbiter.sv
// Shares one AXI4-Lite master port between N_REQ requesters; round-robin grant,
// one outstanding single-beat transaction, one-cycle completion pulse to the owner.
module axi4_lite_master_arbiter
  import axi4_lite_master_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                        i_aclk,
  input  logic                        i_aresetn,
  input  logic [N_REQ-1:0]            i_req_valid,
  output logic [N_REQ-1:0]            o_req_ready,
  input  logic [N_REQ-1:0]            i_req_write,
  input  logic [N_REQ*ADDR_W-1:0]     i_req_addr,
  input  logic [N_REQ*DATA_W-1:0]     i_req_wdata,
  input  logic [N_REQ*DATA_W/8-1:0]   i_req_wstrb,
  output logic [N_REQ-1:0]            o_rsp_valid,
  output logic [DATA_W-1:0]           o_rsp_rdata,
  output logic [1:0]                  o_rsp_resp,
  axi4_lite_master_arbiter_if.master  m_axi
);

  localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned STRB_W = DATA_W / 8;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    r_grant_idx;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic                r_awvalid;
  logic                r_wvalid;
  logic                r_arvalid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  resp_t               r_rsp_resp;
  logic [N_REQ-1:0]    w_grant;
  logic [IDX_W-1:0]    w_grant_idx;

  axi4_lite_master_arbiter_rr_arbiter #(
    .N (N_REQ)
  ) u_rr_arbiter (
    .i_req       (i_req_valid),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  assign m_axi.awaddr  = r_addr;
  assign m_axi.awprot  = PROT_DEFAULT;
  assign m_axi.awvalid = r_awvalid;
  assign m_axi.wdata   = r_wdata;
  assign m_axi.wstrb   = r_wstrb;
  assign m_axi.wvalid  = r_wvalid;
  assign m_axi.araddr  = r_addr;
  assign m_axi.arprot  = PROT_DEFAULT;
  assign m_axi.arvalid = r_arvalid;
  assign o_rsp_rdata   = r_rsp_rdata;
  assign o_rsp_resp    = r_rsp_resp;

  always_comb begin
    w_state_nxt  = r_state;
    o_req_ready  = '0;
    o_rsp_valid  = '0;
    m_axi.bready = 1'b0;
    m_axi.rready = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (|i_req_valid) begin
          o_req_ready = w_grant;
          w_state_nxt = i_req_write[w_grant_idx] ? StWrAwW : StRdAr;
        end
      end
      StWrAwW: begin
        // AW and W complete independently; leave once neither is still pending.
        if ((!r_awvalid || m_axi.awready) && (!r_wvalid || m_axi.wready)) begin
          w_state_nxt = StWrB;
        end
      end
      StWrB: begin
        m_axi.bready = 1'b1;
        if (m_axi.bvalid) w_state_nxt = StRsp;
      end
      StRdAr: begin
        if (m_axi.arready) w_state_nxt = StRdR;
      end
      StRdR: begin
        m_axi.rready = 1'b1;
        if (m_axi.rvalid) w_state_nxt = StRsp;
      end
      StRsp: begin
        o_rsp_valid[r_grant_idx] = 1'b1;
        w_state_nxt              = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_aclk) begin
    if (!i_aresetn) begin
      r_state     <= StIdle;
      r_ptr       <= '0;
      r_grant_idx <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= RespOkay;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        StIdle: begin
          if (|i_req_valid) begin
            r_grant_idx <= w_grant_idx;
            r_ptr       <= (w_grant_idx == IDX_W'(N_REQ - 1)) ? '0 : w_grant_idx + IDX_W'(1);
            r_addr      <= i_req_addr[w_grant_idx*ADDR_W +: ADDR_W];
            r_wdata     <= i_req_wdata[w_grant_idx*DATA_W +: DATA_W];
            r_wstrb     <= i_req_wstrb[w_grant_idx*STRB_W +: STRB_W];
            r_awvalid   <= i_req_write[w_grant_idx];
            r_wvalid    <= i_req_write[w_grant_idx];
            r_arvalid   <= !i_req_write[w_grant_idx];
          end
        end
        StWrAwW: begin
          if (m_axi.awready) r_awvalid <= 1'b0;
          if (m_axi.wready)  r_wvalid  <= 1'b0;
        end
        StWrB: begin
          if (m_axi.bvalid) begin
            r_rsp_resp  <= resp_t'(m_axi.bresp);
            r_rsp_rdata <= '0;
          end
        end
        StRdAr: begin
          if (m_axi.arready) r_arvalid <= 1'b0;
        end
        StRdR: begin
          if (m_axi.rvalid) begin
            r_rsp_rdata <= m_axi.rdata;
            r_rsp_resp  <= resp_t'(m_axi.rresp);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_master_arbiter.sv
// Directed bench for axi4_lite_master_arbiter with a small behavioural AXI4-Lite memory slave.
module tb_axi4_lite_master_arbiter;

  logic          clk;
  logic          aresetn;
  logic [3:0]    req_valid;
  logic [3:0]    req_ready;
  logic [3:0]    req_write;
  logic [127:0]  req_addr;
  logic [127:0]  req_wdata;
  logic [15:0]   req_wstrb;
  logic [3:0]    rsp_valid;
  logic [31:0]   rsp_rdata;
  logic [1:0]    rsp_resp;

  int n_tests = 0;
  int n_fail  = 0;

  axi4_lite_master_arbiter_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  axi4_lite_master_arbiter #(
    .N_REQ  (4),
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .i_aclk      (clk),
    .i_aresetn   (aresetn),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_write (req_write),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .i_req_wstrb (req_wstrb),
    .o_rsp_valid (rsp_valid),
    .o_rsp_rdata (rsp_rdata),
    .o_rsp_resp  (rsp_resp),
    .m_axi       (axi)
  );

  initial begin
    clk = 1'b0;
    forever #2 clk = ~clk;
  end

  // ---------------- behavioural slave ----------------
  int          aw_delay = 0;
  int          b_delay  = 0;
  int          aw_cnt   = 0;
  int          b_cnt    = 0;
  int          aw_beats = 0;
  bit          aw_got   = 0;
  bit          w_got    = 0;
  bit          b_pend   = 0;
  logic [31:0] mem [64] = '{default: '0};
  logic [31:0] last_awaddr = '0;
  logic [31:0] last_wdata  = '0;
  logic [3:0]  last_wstrb  = '0;
  logic        aw_hs, w_hs;
  logic [31:0] use_addr, use_data;
  logic [3:0]  use_strb;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  assign axi.awready = axi.awvalid && (aw_cnt >= aw_delay);
  assign axi.wready  = axi.wvalid;
  assign axi.arready = axi.arvalid;
  assign axi.bvalid  = b_pend && (b_cnt >= b_delay);
  assign axi.bresp   = 2'b00;
  assign aw_hs       = axi.awvalid && axi.awready;
  assign w_hs        = axi.wvalid && axi.wready;
  assign use_addr    = aw_hs ? axi.awaddr : last_awaddr;
  assign use_data    = w_hs ? axi.wdata : last_wdata;
  assign use_strb    = w_hs ? axi.wstrb : last_wstrb;

  always @(posedge clk) begin
    if (!aresetn) begin
      aw_cnt     <= 0;
      b_cnt      <= 0;
      aw_got     <= 0;
      w_got      <= 0;
      b_pend     <= 0;
      axi.rvalid <= 1'b0;
      axi.rdata  <= '0;
      axi.rresp  <= 2'b00;
    end else begin
      aw_cnt <= (axi.awvalid && !axi.awready) ? aw_cnt + 1 : 0;
      if (aw_hs) begin
        last_awaddr <= axi.awaddr;
        aw_beats    <= aw_beats + 1;
      end
      if (w_hs) begin
        last_wdata <= axi.wdata;
        last_wstrb <= axi.wstrb;
      end
      if ((aw_hs || w_hs) && (aw_got || aw_hs) && (w_got || w_hs)) begin
        mem[use_addr[7:2]] <= merge(mem[use_addr[7:2]], use_data, use_strb);
        b_pend <= 1;
        aw_got <= 0;
        w_got  <= 0;
      end else begin
        if (aw_hs) aw_got <= 1;
        if (w_hs)  w_got  <= 1;
      end
      if (axi.bvalid && axi.bready) begin
        b_pend <= 0;
        b_cnt  <= 0;
      end else if (b_pend) begin
        b_cnt <= b_cnt + 1;
      end
      if (axi.arvalid && axi.arready) begin
        axi.rvalid <= 1'b1;
        axi.rdata  <= (axi.araddr == 32'h100) ? 32'hBAD0_0100 : mem[axi.araddr[7:2]];
        axi.rresp  <= (axi.araddr == 32'h100) ? 2'b10 : 2'b00;
      end else if (axi.rvalid && axi.rready) begin
        axi.rvalid <= 1'b0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int idx, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb);
    req_write[idx]          = wr;
    req_addr[idx*32 +: 32]  = addr;
    req_wdata[idx*32 +: 32] = data;
    req_wstrb[idx*4 +: 4]   = strb;
    req_valid[idx]          = 1'b1;
  endtask

  // Called at a falling edge with the request already raised; returns just after
  // the accepting rising edge with valid dropped.
  task automatic wait_grant(input int idx, input string tag);
    int ok;
    ok = 0;
    for (int c = 0; c < 50 && ok == 0; c++) begin
      #1;
      if (req_ready[idx]) begin
        ok = 1;
        @(posedge clk);
        #1 req_valid[idx] = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    check({tag, "_grant"}, 64'(ok), 64'd1);
  endtask

  // Latency counted in falling edges after the grant cycle.
  task automatic wait_rsp(input int idx, input string tag, input logic [31:0] exp_rdata,
                          input logic [1:0] exp_resp, input int exp_lat);
    int lat;
    logic [31:0] rd;
    logic [1:0] rs;
    lat = -1;
    rd  = 'x;
    rs  = 'x;
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      @(negedge clk);
      if (rsp_valid[idx]) begin
        lat = k;
        rd  = rsp_rdata;
        rs  = rsp_resp;
      end
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_rdata"}, 64'(rd), 64'(exp_rdata));
    check({tag, "_resp"}, 64'(rs), 64'(exp_resp));
    @(negedge clk);
    check({tag, "_pulse1"}, 64'(rsp_valid), 64'd0);
  endtask

  task automatic do_txn(input int idx, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        input logic [31:0] exp_rdata, input logic [1:0] exp_resp,
                        input string tag);
    @(negedge clk);
    issue(idx, wr, addr, data, strb);
    wait_grant(idx, tag);
    wait_rsp(idx, tag, exp_rdata, exp_resp, 3);
  endtask

  // Raise every requester in mask together and record the grant order.
  task automatic run_group(input logic [3:0] mask, input int exp_order[4], input int n_exp,
                           input string tag);
    int order[4];
    int gcyc[4];
    int n;
    int cyc;
    @(negedge clk);
    for (int i = 0; i < 4; i++) if (mask[i]) issue(i, 1'b0, 32'(i * 4), '0, '0);
    n   = 0;
    cyc = 0;
    while (n < n_exp && cyc < 200) begin
      #1;
      if (req_ready != 4'b0) begin
        for (int i = 0; i < 4; i++) if (req_ready[i]) order[n] = i;
        check({tag, "_onehot"}, 64'($countones(req_ready)), 64'd1);
        gcyc[n] = cyc;
        n++;
        @(posedge clk);
        #1 req_valid[order[n-1]] = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, "_count"}, 64'(n), 64'(n_exp));
    for (int i = 0; i < n && i < n_exp; i++) begin
      check($sformatf("%s_order%0d", tag, i), 64'(order[i]), 64'(exp_order[i]));
      if (i > 0) check($sformatf("%s_gap%0d", tag, i), 64'(gcyc[i] - gcyc[i-1]), 64'd4);
    end
    repeat (4) @(negedge clk);
    req_valid = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int ord_all[4];
    int ord_20[4];
    ord_all   = '{0, 1, 2, 3};
    ord_20    = '{0, 2, 0, 0};
    aresetn   = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;

    @(negedge clk);
    @(negedge clk);
    check("rst_awvalid", 64'(axi.awvalid), 64'd0);
    check("rst_wvalid", 64'(axi.wvalid), 64'd0);
    check("rst_arvalid", 64'(axi.arvalid), 64'd0);
    check("rst_bready", 64'(axi.bready), 64'd0);
    check("rst_rready", 64'(axi.rready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_awaddr", 64'(axi.awaddr), 64'd0);
    check("rst_prot", 64'({axi.awprot, axi.arprot}), 64'd0);
    #3 aresetn = 1'b1;

    // 1: single write from requester 0
    do_txn(0, 1'b1, 32'h0, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b00, "t1_wr");
    check("t1_aw_beats", 64'(aw_beats), 64'd1);
    check("t1_awaddr", 64'(last_awaddr), 64'h0);
    check("t1_wdata", 64'(last_wdata), 64'hDEAD_BEEF);
    check("t1_wstrb", 64'(last_wstrb), 64'hF);

    // 2: writes then read-back from requester 1
    do_txn(1, 1'b1, 32'h4, 32'h0000_0001, 4'hF, 32'h0, 2'b00, "t2_wr4");
    do_txn(1, 1'b1, 32'h8, 32'h0000_0002, 4'hF, 32'h0, 2'b00, "t2_wr8");
    do_txn(1, 1'b0, 32'h0, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00, "t2_rd0");
    do_txn(1, 1'b0, 32'h4, 32'h0, 4'h0, 32'h0000_0001, 2'b00, "t2_rd4");
    do_txn(1, 1'b0, 32'h8, 32'h0, 4'h0, 32'h0000_0002, 2'b00, "t2_rd8");

    // requester 3 moves the round-robin pointer back to 0
    do_txn(3, 1'b0, 32'h8, 32'h0, 4'h0, 32'h0000_0002, 2'b00, "t3_pre");

    // 3: all four held, then requesters 2 and 0
    run_group(4'b1111, ord_all, 4, "t3_all");
    run_group(4'b0101, ord_20, 2, "t3_20");

    // 4: awready delayed 3 cycles, wready immediate; partial strobe write
    aw_delay = 3;
    @(negedge clk);
    issue(0, 1'b1, 32'hC, 32'h1234_5678, 4'h3);
    wait_grant(0, "t4");
    @(negedge clk);
    check("t4_c1_awvalid", 64'(axi.awvalid), 64'd1);
    check("t4_c1_wvalid", 64'(axi.wvalid), 64'd1);
    check("t4_c1_bready", 64'(axi.bready), 64'd0);
    @(negedge clk);
    issue(1, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    check("t4_c2_wvalid", 64'(axi.wvalid), 64'd0);
    check("t4_c2_awvalid", 64'(axi.awvalid), 64'd1);
    check("t4_c2_bready", 64'(axi.bready), 64'd0);
    check("t4_c2_ready_busy", 64'(req_ready), 64'd0);
    @(negedge clk);
    #1;
    check("t4_c3_awvalid", 64'(axi.awvalid), 64'd1);
    check("t4_c3_ready_busy", 64'(req_ready), 64'd0);
    req_valid[1] = 1'b0;
    @(negedge clk);
    check("t4_c4_awready", 64'({axi.awvalid, axi.awready}), 64'b11);
    check("t4_c4_bready", 64'(axi.bready), 64'd0);
    @(negedge clk);
    check("t4_c5_awvalid", 64'(axi.awvalid), 64'd0);
    check("t4_c5_bready", 64'(axi.bready), 64'd1);
    wait_rsp(0, "t4", 32'h0, 2'b00, 1);
    aw_delay = 0;
    check("t4_aw_beats", 64'(aw_beats), 64'd4);
    check("t4_awaddr", 64'(last_awaddr), 64'hC);
    check("t4_wstrb", 64'(last_wstrb), 64'h3);
    do_txn(1, 1'b0, 32'hC, 32'h0, 4'h0, 32'h0000_5678, 2'b00, "t4_rdC");

    // 5: slave error forwarded, arbiter returns to idle
    do_txn(2, 1'b0, 32'h100, 32'h0, 4'h0, 32'hBAD0_0100, 2'b10, "t5_slverr");
    do_txn(0, 1'b0, 32'h4, 32'h0, 4'h0, 32'h0000_0001, 2'b00, "t5_after");

    // 6: reset pulse while waiting for B
    b_delay = 5;
    @(negedge clk);
    issue(3, 1'b1, 32'h10, 32'hA5A5_A5A5, 4'hF);
    wait_grant(3, "t6");
    @(negedge clk);
    @(negedge clk);
    check("t6_in_wr_b", 64'(axi.bready), 64'd1);
    aresetn = 1'b0;
    @(posedge clk);
    #1 aresetn = 1'b1;
    b_delay = 0;
    @(negedge clk);
    check("t6_rst_bready", 64'(axi.bready), 64'd0);
    check("t6_rst_valids", 64'({axi.awvalid, axi.wvalid, axi.arvalid, axi.rready}), 64'd0);
    check("t6_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("t6_rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("t6_rst_rsp_resp", 64'(rsp_resp), 64'd0);
    check("t6_rst_payload", 64'({axi.awaddr, axi.wdata}), 64'd0);
    check("t6_rst_wstrb", 64'(axi.wstrb), 64'd0);
    do_txn(3, 1'b1, 32'h10, 32'h5A5A_5A5A, 4'hF, 32'h0, 2'b00, "t6_wr");
    do_txn(3, 1'b0, 32'h10, 32'h0, 4'h0, 32'h5A5A_5A5A, 2'b00, "t6_rd");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
